// File: rtl/sseg_pkg.sv
// sseg_pkg -- shared types and constants for the seven-segment scan controller.
//   N_DIGITS / N_SUB : digits per frame and PWM sub-steps per digit slot
//   sseg_t           : one active-low segment pattern {dp,g,f,e,d,c,b,a}
//   slot_state_t     : phase of the current digit slot
//   slot_state_of()  : slot phase implied by a sub-step index and brightness
package sseg_pkg;

    localparam int N_DIGITS = 4;
    localparam int N_SUB    = 16;
    localparam int DIG_W    = $clog2(N_DIGITS);
    localparam int SUB_W    = $clog2(N_SUB);

    typedef logic [7:0] sseg_t;

    typedef enum logic [1:0] {
        S_BLANK,
        S_ON,
        S_OFF
    } slot_state_t;

    // Sub-step 0 is always dead time; the next 'bright' sub-steps are lit.
    function automatic slot_state_t slot_state_of(input logic [SUB_W-1:0] sub,
                                                  input logic [3:0]       bright);
        if (sub == '0) begin
            return S_BLANK;
        end else if (sub <= bright) begin
            return S_ON;
        end else begin
            return S_OFF;
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen -- clock-enable prescaler for the scan scheduler.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   en    : count enable; low holds the divider where it is
//   tick  : one-cycle pulse on the last count of every P_TICK_DIV-cycle period
module tick_gen #(
    parameter int P_TICK_DIV = 6250
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int DIV_W = (P_TICK_DIV > 1) ? $clog2(P_TICK_DIV) : 1;

    logic [DIV_W-1:0] r_div;

    assign tick = en && (r_div == DIV_W'(P_TICK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl -- 4-digit multiplexed seven-segment scan controller with
// dead-time blanking, 16-step PWM brightness and frame-synchronous shadow load.
//   i_clk      : system clock
//   i_reset    : synchronous, active-high reset
//   i_en       : scan enable; low freezes the scan and blanks the outputs
//   i_in_n     : active-low patterns per digit, index 0 = rightmost
//   i_digit_en : per-digit enable mask (a 0 blanks that slot)
//   i_bright   : brightness, 0 = dark, 15 = 15/16 duty
//   o_ldsel    : one-hot active-high digit select, 0 when blank
//   o_sseg_n   : active-low segments, 8'hFF when blank
//   o_frame    : one-cycle pulse on the first blank cycle of digit 0
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int P_TICK_DIV = 6250
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_en,
    input  logic [N_DIGITS-1:0][7:0]    i_in_n,
    input  logic [N_DIGITS-1:0]         i_digit_en,
    input  logic [3:0]                  i_bright,
    output logic [N_DIGITS-1:0]         o_ldsel,
    output logic [7:0]                  o_sseg_n,
    output logic                        o_frame
);

    logic [SUB_W-1:0]     r_sub, sub_next;
    logic [DIG_W-1:0]     r_dig, dig_next;
    logic [3:0]           r_bright, bright_next;
    slot_state_t          r_state, state_next;
    logic                 r_init;        // first cycle after reset release
    logic                 r_frame_flag;  // counters have just entered a frame
    sseg_t [N_DIGITS-1:0] r_shadow;
    logic [N_DIGITS-1:0]  r_shadow_en;

    logic                 tick;
    logic                 div_en;
    logic                 load;
    logic                 show;

    // The release cycle acts as a frame start in place: it loads the shadow
    // while the counters stay at position zero.
    assign div_en = i_en && !r_init;

    tick_gen #(
        .P_TICK_DIV (P_TICK_DIV)
    ) u_tick_gen (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (div_en),
        .tick  (tick)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        sub_next    = r_sub;
        dig_next    = r_dig;
        bright_next = r_bright;
        state_next  = r_state;
        load        = r_init;

        if (r_init) begin
            bright_next = i_bright;
        end

        if (tick) begin
            sub_next = r_sub + SUB_W'(1);
            if (r_sub == SUB_W'(N_SUB - 1)) begin
                dig_next    = r_dig + DIG_W'(1);
                bright_next = i_bright;
                if (r_dig == DIG_W'(N_DIGITS - 1)) begin
                    load = 1'b1;
                end
            end
            state_next = slot_state_of(sub_next, bright_next);
        end
    end

    assign show = i_en && (r_state == S_ON) && r_shadow_en[r_dig];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sub        <= '0;
            r_dig        <= '0;
            r_bright     <= '0;
            r_state      <= S_BLANK;
            r_init       <= 1'b1;
            r_frame_flag <= 1'b0;
            // NOTE: the shadow is reset explicitly because it is read before
            // its first load; all-ones is the blank pattern.
            r_shadow     <= '1;
            r_shadow_en  <= '0;
            o_ldsel      <= '0;
            o_sseg_n     <= 8'hFF;
            o_frame      <= 1'b0;
        end else begin
            r_sub        <= sub_next;
            r_dig        <= dig_next;
            r_bright     <= bright_next;
            r_state      <= state_next;
            r_init       <= 1'b0;
            r_frame_flag <= load;
            if (load) begin
                r_shadow    <= i_in_n;
                r_shadow_en <= i_digit_en;
            end
            // Outputs reflect the counter state one cycle behind, so o_frame
            // lines up with the first blank output cycle of digit 0.
            o_frame  <= r_frame_flag;
            o_ldsel  <= show ? (N_DIGITS'(1) << r_dig) : '0;
            o_sseg_n <= show ? r_shadow[r_dig] : 8'hFF;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl -- directed self-checking bench for sseg_scan_ctrl with
// a prescaler of 4 (64-cycle slot, 256-cycle frame). Cycle n is the output
// seen after the n-th rising edge following reset release (edge 0).
module tb_sseg_scan_ctrl;

    localparam int DIV   = 4;
    localparam int SLOT  = 16 * DIV;
    localparam int FRAME = 4 * SLOT;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [3:0][7:0]  in_n;
    logic [3:0]       digit_en;
    logic [3:0]       bright;
    logic [3:0]       ldsel;
    logic [7:0]       sseg_n;
    logic             frame;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0][7:0]  pats_a;
    logic [3:0][7:0]  pats_b;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .P_TICK_DIV (DIV)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_en       (en),
        .i_in_n     (in_n),
        .i_digit_en (digit_en),
        .i_bright   (bright),
        .o_ldsel    (ldsel),
        .o_sseg_n   (sseg_n),
        .o_frame    (frame)
    );

    // Expected outputs for scan position q (cycles since frame start).
    function automatic void exp_out(input int q, input logic [3:0] br,
                                    input logic [3:0] mask, input logic [3:0][7:0] pats,
                                    output logic [3:0] e_ld, output logic [7:0] e_seg,
                                    output logic e_fr);
        int d;
        int s;
        d = (q % FRAME) / SLOT;
        s = (q % SLOT) / DIV;
        e_fr = ((q % FRAME) == 0);
        if (s >= 1 && s <= int'(br) && mask[d]) begin
            e_ld  = 4'b0001 << d;
            e_seg = pats[d];
        end else begin
            e_ld  = 4'b0000;
            e_seg = 8'hFF;
        end
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Pulse reset for two edges and return at cycle 0.
    task automatic release_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        en       = 1'b1;
        bright   = 4'd15;
        digit_en = 4'b1111;
        in_n     = pats_a;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ldsel !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ldsel: got %b want 0000", ldsel);
        end
        n_checks++;
        if (sseg_n !== 8'hFF) begin
            n_fail++; $display("FAIL reset_sseg: got %h want ff", sseg_n);
        end
        n_checks++;
        if (frame !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame: got %b want 0", frame);
        end
        reset = 1'b0;
        next_cycle();
        e_ld = 4'b0000; e_seg = 8'hFF; e_fr = 1'b0;
        n_checks++;
        if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
            n_fail++;
            $display("FAIL release_c0: got %b %h %b want %b %h %b", ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
        end
    endtask

    // Continues from cycle 0 left by test_reset: two full frames at 15/16.
    task automatic test_scan();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        for (int n = 1; n <= 2 * FRAME; n++) begin
            next_cycle();
            exp_out(n - 1, 4'd15, 4'b1111, pats_a, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL scan c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
        end
    endtask

    task automatic test_bright();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        int         on_cnt;
        bright = 4'd3;
        release_reset();
        on_cnt = 0;
        for (int n = 1; n <= FRAME; n++) begin
            next_cycle();
            if (ldsel != 4'b0000) on_cnt++;
            exp_out(n - 1, 4'd3, 4'b1111, pats_a, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL bright3 c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
        end
        n_checks++;
        if (on_cnt != 4 * 12) begin
            n_fail++; $display("FAIL bright3_on_count: got %0d want 48", on_cnt);
        end

        bright = 4'd0;
        release_reset();
        for (int n = 1; n <= 2 * FRAME + 20; n++) begin
            next_cycle();
            e_fr = (((n - 1) % FRAME) == 0);
            n_checks++;
            if (ldsel !== 4'b0000 || sseg_n !== 8'hFF || frame !== e_fr) begin
                n_fail++;
                $display("FAIL bright0 c%0d: got %b %h %b want 0000 ff %b", n, ldsel, sseg_n, frame, e_fr);
            end
        end
        bright = 4'd15;
    endtask

    task automatic test_shadow();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        in_n = pats_a;
        release_reset();
        for (int n = 1; n <= 2 * FRAME; n++) begin
            next_cycle();
            exp_out(n - 1, 4'd15, 4'b1111, (n - 1 < FRAME) ? pats_a : pats_b, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL shadow c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
            // Mid digit-1 ON: change digit 2 only.
            if (n == 70) in_n = pats_b;
        end
        in_n = pats_a;
    endtask

    task automatic test_mask();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        int         d2_lit;
        int         d3_lit;
        digit_en = 4'b1011;
        release_reset();
        d2_lit = 0;
        d3_lit = 0;
        for (int n = 1; n <= FRAME; n++) begin
            next_cycle();
            if (n >= 129 && n <= 192 && ldsel != 4'b0000) d2_lit++;
            if (ldsel == 4'b1000 && sseg_n == 8'hB0) d3_lit++;
            exp_out(n - 1, 4'd15, 4'b1011, pats_a, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL mask c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
        end
        n_checks++;
        if (d2_lit != 0) begin
            n_fail++; $display("FAIL mask_d2_lit: got %0d want 0", d2_lit);
        end
        n_checks++;
        if (d3_lit != 60) begin
            n_fail++; $display("FAIL mask_d3_lit: got %0d want 60", d3_lit);
        end
        digit_en = 4'b1111;
    endtask

    task automatic test_enable();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        release_reset();
        for (int n = 1; n <= 80; n++) begin
            next_cycle();
            exp_out(n - 1, 4'd15, 4'b1111, pats_a, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL en_pre c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
        end
        en = 1'b0;
        for (int n = 81; n <= 180; n++) begin
            next_cycle();
            n_checks++;
            if (ldsel !== 4'b0000 || sseg_n !== 8'hFF || frame !== 1'b0) begin
                n_fail++;
                $display("FAIL en_hold c%0d: got %b %h %b want 0000 ff 0", n, ldsel, sseg_n, frame);
            end
        end
        en = 1'b1;
        // Resumes exactly where it froze: position shifted by 100 cycles.
        for (int n = 181; n <= 400; n++) begin
            next_cycle();
            exp_out(n - 101, 4'd15, 4'b1111, pats_a, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL en_post c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_ld;
        logic [7:0] e_seg;
        logic       e_fr;
        release_reset();
        repeat (150) next_cycle();
        n_checks++;
        if (ldsel !== 4'b0100 || sseg_n !== 8'hA4) begin
            n_fail++; $display("FAIL rmid_pre: got %b %h want 0100 a4", ldsel, sseg_n);
        end
        reset = 1'b1;
        next_cycle();
        n_checks++;
        if (ldsel !== 4'b0000 || sseg_n !== 8'hFF || frame !== 1'b0) begin
            n_fail++; $display("FAIL rmid_blank: got %b %h %b want 0000 ff 0", ldsel, sseg_n, frame);
        end
        reset = 1'b0;
        next_cycle();
        n_checks++;
        if (ldsel !== 4'b0000 || sseg_n !== 8'hFF || frame !== 1'b0) begin
            n_fail++; $display("FAIL rmid_c0: got %b %h %b want 0000 ff 0", ldsel, sseg_n, frame);
        end
        for (int n = 1; n <= 80; n++) begin
            next_cycle();
            exp_out(n - 1, 4'd15, 4'b1111, pats_a, e_ld, e_seg, e_fr);
            n_checks++;
            if (ldsel !== e_ld || sseg_n !== e_seg || frame !== e_fr) begin
                n_fail++;
                $display("FAIL rmid_post c%0d: got %b %h %b want %b %h %b", n, ldsel, sseg_n, frame, e_ld, e_seg, e_fr);
            end
        end
    endtask

    initial begin
        pats_a = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
        pats_b = {8'hB0, 8'h92, 8'hF9, 8'hC0};
        test_reset();
        test_scan();
        test_bright();
        test_shadow();
        test_mask();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
